// File: rtl/par16_transmitter.sv
// par16_transmitter: FPGA->master side of the 16-bit parallel bus.
// Packs bytes (MSB first) into 16-bit words, queues them in a small FIFO and
// presents one word per master bus_clk cycle while the master holds bus_rnw high.
// Optional feature macro: PAR16_TX_FLUSH_EN (adds the flush port and PAD_BYTE).
module par16_transmitter #(
  parameter int FIFO_AW = 2
`ifdef PAR16_TX_FLUSH_EN
  , parameter logic [7:0] PAD_BYTE = 8'h00
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         txd_data,
  input  logic               txd_valid,
  output logic               txd_ready,
`ifdef PAR16_TX_FLUSH_EN
  input  logic               flush,
`endif
  input  logic               bus_clk,
  input  logic               bus_rnw,
  output logic [15:0]        bus_data,
  output logic               bus_data_oe,
  output logic [FIFO_AW:0]   words_pending,
  output logic               busy
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] PTR_ONE = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    PRESENT = 2'd2
  } state_t;

  // Synchroniser flops for the master-owned signals
  logic bus_clk_meta_q, clk_s_q;
  logic rnw_meta_q, rnw_s_q;

  // Byte packer state
  logic [7:0]  msb_q, msb_d;
  logic        msb_valid_q, msb_valid_d;

  // Word FIFO: pointers carry one extra wrap bit to tell full from empty
  logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
  logic [15:0]      mem_q [DEPTH];
  logic             fifo_full, fifo_empty;
  logic [15:0]      fifo_head;

  logic        accept;
  logic        push, pop;
  logic [15:0] push_word;

  // Bus-side FSM and its registered outputs
  state_t      state_q;
  logic [15:0] bus_data_q;
  logic        oe_q;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                      (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign fifo_head  = mem_q[rd_ptr_q[FIFO_AW-1:0]];

  assign txd_ready     = !fifo_full;
  assign accept        = txd_valid && txd_ready;
  assign words_pending = wr_ptr_q - rd_ptr_q;
  assign busy          = msb_valid_q || !fifo_empty;
  assign bus_data      = bus_data_q;
  assign bus_data_oe   = oe_q;

  // Two-flop synchronisers bring bus_clk and bus_rnw into the clk domain
  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, and resets asynchronously on reset's rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_clk_meta_q <= 1'b0;
      clk_s_q        <= 1'b0;
      rnw_meta_q     <= 1'b0;
      rnw_s_q        <= 1'b0;
    end else begin
      bus_clk_meta_q <= bus_clk;
      clk_s_q        <= bus_clk_meta_q;
      rnw_meta_q     <= bus_rnw;
      rnw_s_q        <= rnw_meta_q;
    end
  end

  // Packer: first byte parks in the MSB holder, second byte completes a word
  // NOTE: every signal gets a default first so no latch is inferred.
  always_comb begin
    msb_d       = msb_q;
    msb_valid_d = msb_valid_q;
    push        = 1'b0;
    push_word   = {msb_q, txd_data};
    if (accept) begin
      if (!msb_valid_q) begin
        msb_d       = txd_data;
        msb_valid_d = 1'b1;
      end else begin
        push        = 1'b1;
        msb_valid_d = 1'b0;
      end
    end
`ifdef PAR16_TX_FLUSH_EN
    // A real byte always takes precedence over padding
    else if (flush && msb_valid_q && !fifo_full) begin
      push        = 1'b1;
      push_word   = {msb_q, PAD_BYTE};
      msb_valid_d = 1'b0;
    end
`endif
  end

  // FIFO pointer updates; a pop only happens once the master has sampled the word
  always_comb begin
    pop      = (state_q == PRESENT) && rnw_s_q && clk_s_q && !fifo_empty;
    wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
  end

  // Packer and FIFO control registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      msb_q       <= 8'h00;
      msb_valid_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      msb_q       <= msb_d;
      msb_valid_q <= msb_valid_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // FIFO storage write port
  // NOTE: storage is deliberately not reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[FIFO_AW-1:0]] <= push_word;
    end
  end

  // Bus FSM: load the head while bus_clk is low, pop once the master sampled it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      bus_data_q <= 16'h0000;
      oe_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rnw_s_q) begin
            state_q <= LOAD;
            oe_q    <= 1'b1;
          end
        end
        LOAD: begin
          if (!rnw_s_q) begin
            state_q <= IDLE;
            oe_q    <= 1'b0;
          end else if (!fifo_empty && !clk_s_q) begin
            bus_data_q <= fifo_head;
            state_q    <= PRESENT;
          end
        end
        PRESENT: begin
          // A read aborted before sampling leaves the word queued for next time
          if (!rnw_s_q) begin
            state_q <= IDLE;
            oe_q    <= 1'b0;
          end else if (clk_s_q) begin
            state_q <= LOAD;
          end
        end
        default: begin
          state_q <= IDLE;
          oe_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_par16_transmitter.sv
// Scoreboard bench for par16_transmitter: stimulus queues expected words, a
// monitor compares each word the emulated master samples on rising bus_clk.
module tb_par16_transmitter;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  txd_data;
  logic        txd_valid;
  logic        txd_ready;
  logic        flush;
  logic        bus_clk;
  logic        bus_rnw;
  logic [15:0] bus_data;
  logic        bus_data_oe;
  logic [2:0]  words_pending;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];
  logic        sample_en = 1'b0;

  par16_transmitter #(.FIFO_AW(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .txd_data     (txd_data),
    .txd_valid    (txd_valid),
    .txd_ready    (txd_ready),
`ifdef PAR16_TX_FLUSH_EN
    .flush        (flush),
`endif
    .bus_clk      (bus_clk),
    .bus_rnw      (bus_rnw),
    .bus_data     (bus_data),
    .bus_data_oe  (bus_data_oe),
    .words_pending(words_pending),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    txd_data  = b;
    txd_valid = 1'b1;
    while (!txd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("push_timeout", 32'd1, 32'd0);
    @(posedge clk);
    @(negedge clk);
    txd_valid = 1'b0;
  endtask

  // Push two bytes and record the word the master should eventually read
  task automatic push_word(input logic [15:0] w);
    exp_q.push_back(w);
    push_byte(w[15:8]);
    push_byte(w[7:0]);
  endtask

  // One master read cycle: low phase, then rising edge where the master samples
  task automatic bus_read();
    @(negedge clk);
    bus_clk = 1'b0;
    wait_clk(8);
    sample_en = 1'b1;
    bus_clk   = 1'b1;
    wait_clk(8);
    sample_en = 1'b0;
  endtask

  task automatic bus_toggle();
    @(negedge clk);
    bus_clk = 1'b0;
    wait_clk(8);
    bus_clk = 1'b1;
    wait_clk(8);
  endtask

  task automatic set_rnw(input logic v);
    @(negedge clk);
    bus_rnw = v;
    wait_clk(8);
  endtask

  // Monitor: compare each sampled word against the scoreboard head
  initial begin
    logic [15:0] exp_w;
    forever begin
      @(posedge bus_clk);
      if (sample_en) begin
        check("sample_oe", {31'd0, bus_data_oe}, 32'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_sample", 32'd1, 32'd0);
        end else begin
          exp_w = exp_q.pop_front();
          check("bus_word", {16'd0, bus_data}, {16'd0, exp_w});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    txd_data  = 8'h00;
    txd_valid = 1'b0;
    flush     = 1'b0;
    bus_clk   = 1'b1;
    bus_rnw   = 1'b0;
    wait_clk(3);
    check("rst_oe",    {31'd0, bus_data_oe}, 32'd0);
    check("rst_data",  {16'd0, bus_data}, 32'd0);
    check("rst_wp",    {29'd0, words_pending}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    reset = 1'b0;
    wait_clk(2);
    check("rst_ready", {31'd0, txd_ready}, 32'd1);

    // 1: two words read in order
    push_word(16'h1234);
    push_word(16'h5678);
    check("t1_wp2",   {29'd0, words_pending}, 32'd2);
    check("t1_busy1", {31'd0, busy}, 32'd1);
    set_rnw(1'b1);
    check("t1_oe",    {31'd0, bus_data_oe}, 32'd1);
    bus_read();
    check("t1_wp1",   {29'd0, words_pending}, 32'd1);
    bus_read();
    check("t1_wp0",   {29'd0, words_pending}, 32'd0);
    check("t1_busy0", {31'd0, busy}, 32'd0);
    set_rnw(1'b0);
    check("t1_oe_off", {31'd0, bus_data_oe}, 32'd0);

    // 2: fill the FIFO, 9th byte stalls until a word is read
    push_word(16'h0102);
    push_word(16'h0304);
    push_word(16'h0506);
    push_word(16'h0708);
    check("t2_full_wp",    {29'd0, words_pending}, 32'd4);
    check("t2_full_ready", {31'd0, txd_ready}, 32'd0);
    exp_q.push_back(16'h090A);
    @(negedge clk);
    txd_data  = 8'h09;
    txd_valid = 1'b1;
    wait_clk(5);
    check("t2_stall_ready", {31'd0, txd_ready}, 32'd0);
    check("t2_stall_wp",    {29'd0, words_pending}, 32'd4);
    set_rnw(1'b1);
    fork
      bus_read();
      begin
        int n = 0;
        while (!txd_ready && n < 200) begin
          @(negedge clk);
          n++;
        end
        check("t2_stall_release", {31'd0, txd_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        txd_valid = 1'b0;
      end
    join
    push_byte(8'h0A);
    check("t2_wp_after", {29'd0, words_pending}, 32'd4);
    repeat (4) bus_read();
    check("t2_wp_drained", {29'd0, words_pending}, 32'd0);
    set_rnw(1'b0);

    // 3: abort a read mid-PRESENT, word is re-presented and read once
    push_word(16'hAAAA);
    set_rnw(1'b1);
    @(negedge clk);
    bus_clk = 1'b0;
    wait_clk(8);
    check("t3_present_data", {16'd0, bus_data}, 32'h0000AAAA);
    bus_rnw = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t3_oe_drop", {31'd0, bus_data_oe}, 32'd0);
    check("t3_wp_kept", {29'd0, words_pending}, 32'd1);
    set_rnw(1'b1);
    bus_read();
    check("t3_wp_read", {29'd0, words_pending}, 32'd0);

    // 4: empty FIFO with bus_clk toggling holds bus_data, then BEEF appears
    for (int i = 0; i < 3; i++) begin
      bus_toggle();
      check("t4_oe",   {31'd0, bus_data_oe}, 32'd1);
      check("t4_hold", {16'd0, bus_data}, 32'h0000AAAA);
      check("t4_wp",   {29'd0, words_pending}, 32'd0);
    end
    push_word(16'hBEEF);
    bus_read();
    check("t4_wp_end", {29'd0, words_pending}, 32'd0);

    // 5: asynchronous reset while a word is presented
    push_byte(8'h5A);
    push_byte(8'hA5);
    @(negedge clk);
    bus_clk = 1'b0;
    wait_clk(8);
    check("t5_present", {16'd0, bus_data}, 32'h00005AA5);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("t5_oe",   {31'd0, bus_data_oe}, 32'd0);
    check("t5_data", {16'd0, bus_data}, 32'd0);
    check("t5_wp",   {29'd0, words_pending}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    wait_clk(2);
    bus_clk = 1'b1;
    bus_rnw = 1'b0;
    reset   = 1'b0;
    wait_clk(8);

    // 6: lone MSB with and without flush support
    push_byte(8'hC3);
`ifdef PAR16_TX_FLUSH_EN
    exp_q.push_back(16'hC300);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_clk(2);
    check("t6_wp_flush", {29'd0, words_pending}, 32'd1);
    set_rnw(1'b1);
    bus_read();
    check("t6_wp_end",   {29'd0, words_pending}, 32'd0);
    check("t6_busy_end", {31'd0, busy}, 32'd0);
    set_rnw(1'b0);
`else
    wait_clk(10);
    check("t6_wp_lone",   {29'd0, words_pending}, 32'd0);
    check("t6_busy_lone", {31'd0, busy}, 32'd1);
`endif

    check("sb_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
